// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC register and IF/ID pipeline register for the 5-stage RISC-V core.
//            Optional performance counters are enabled by the FETCH_PERF_CNT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter int unsigned     PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            pcwrite_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [PC_W-1:0] branch_target_i,
   input  logic [31:0]     instr_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] ifid_pc_o,
   output logic [31:0]     ifid_instr_o,
   output logic            ifid_valid_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     stall_cnt_o,
   output logic [31:0]     flush_cnt_o,
   output logic [31:0]     fetch_cnt_o,
`endif
   output logic            misalign_o
);

   localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_ifid_pc;
   logic [31:0]     r_ifid_instr;
   logic            r_ifid_valid;
   logic            r_misalign;
   logic [PC_W-1:0] w_pc_plus4;
   logic [PC_W-1:0] w_target_aligned;

   assign w_pc_plus4       = r_pc + PC_W'(4);
   assign w_target_aligned = {branch_target_i[PC_W-1:2], 2'b00};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc         <= RESET_PC;
         r_ifid_pc    <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_valid <= 1'b0;
         r_misalign   <= 1'b0;
      end else if (!start_i) begin
         r_ifid_pc    <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_valid <= 1'b0;
      end else if (stall_i) begin
         // Branch operands are stale during a load-use stall, so any flush waits.
         if (pcwrite_i) begin
            r_pc <= w_pc_plus4;
         end
      end else if (flush_i) begin
         r_pc         <= w_target_aligned;
         r_ifid_pc    <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_valid <= 1'b0;
         if (branch_target_i[1:0] != 2'b00) begin
            r_misalign <= 1'b1;
         end
      end else begin
         r_ifid_pc    <= r_pc;
         r_ifid_instr <= instr_i;
         r_ifid_valid <= 1'b1;
         if (pcwrite_i) begin
            r_pc <= w_pc_plus4;
         end
      end
   end

   assign pc_o         = r_pc;
   assign ifid_pc_o    = r_ifid_pc;
   assign ifid_instr_o = r_ifid_instr;
   assign ifid_valid_o = r_ifid_valid;
   assign misalign_o   = r_misalign;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic [31:0] r_fetch_cnt;
   logic        w_stall_evt;
   logic        w_flush_evt;
   logic        w_fetch_evt;

   assign w_stall_evt = start_i && stall_i;
   assign w_flush_evt = start_i && !stall_i && flush_i;
   assign w_fetch_evt = start_i && !stall_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_fetch_cnt <= '0;
      end else begin
         if (w_stall_evt && r_stall_cnt != c_CNT_MAX) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush_evt && r_flush_cnt != c_CNT_MAX) r_flush_cnt <= r_flush_cnt + 32'd1;
         if (w_fetch_evt && r_fetch_cnt != c_CNT_MAX) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
   assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage (directed plan plus random traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] c_NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pcw = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] tgt = '0;
   logic [31:0] instr;
   logic [31:0] pc, ifid_pc, ifid_instr;
   logic        ifid_valid, misalign;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, fetch_cnt;
`endif

   int nchecks = 0;
   int nerr    = 0;

   typedef struct {
      logic [31:0] pc, ipc, ins, sc, fc, fe;
      logic        v, mis;
   } exp_t;
   exp_t q[$];

   // Reference state: the architectural view of fetch after each edge.
   logic [31:0] m_pc, m_ipc, m_ins, m_sc, m_fc, m_fe;
   logic        m_v, m_mis;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0) return 32'h00A0_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return {a[15:0] ^ 16'h5A5A, a[31:16]} | 32'h13;
   endfunction

   assign instr = imem(pc);

   fetch_stage #(.PC_W(32), .RESET_PC(32'h0), .NOP_INSTR(c_NOP)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .pcwrite_i(pcw),
      .stall_i(stall), .flush_i(flush), .branch_target_i(tgt), .instr_i(instr),
      .pc_o(pc), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
      .ifid_valid_o(ifid_valid),
`ifdef FETCH_PERF_CNT_EN
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .fetch_cnt_o(fetch_cnt),
`endif
      .misalign_o(misalign)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 1;
   endfunction

   // Apply one cycle of stimulus, advance the reference and queue the expectation.
   task automatic step(input logic r, input logic s, input logic w, input logic st,
                       input logic f, input logic [31:0] t);
      exp_t e;
      @(negedge clk);
      rst = r; start = s; pcw = w; stall = st; flush = f; tgt = t;
      if (r) begin
         m_pc = 0; m_ipc = 0; m_ins = c_NOP; m_v = 0; m_mis = 0;
         m_sc = 0; m_fc = 0; m_fe = 0;
      end else if (!s) begin
         m_ipc = 0; m_ins = c_NOP; m_v = 0;
      end else if (st) begin
         m_sc = sat_inc(m_sc);
         if (w) m_pc = m_pc + 4;
      end else if (f) begin
         m_fc = sat_inc(m_fc);
         m_pc = t - (t % 4);
         m_ipc = 0; m_ins = c_NOP; m_v = 0;
         if (t % 4 != 0) m_mis = 1;
      end else begin
         m_fe = sat_inc(m_fe);
         m_ipc = m_pc; m_ins = imem(m_pc); m_v = 1;
         if (w) m_pc = m_pc + 4;
      end
      e.pc = m_pc; e.ipc = m_ipc; e.ins = m_ins; e.v = m_v; e.mis = m_mis;
      e.sc = m_sc; e.fc = m_fc; e.fe = m_fe;
      q.push_back(e);
   endtask

   // Monitor: outputs are registered, so each edge presents one expected state.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            check("pc_o", pc, e.pc);
            check("ifid_pc_o", ifid_pc, e.ipc);
            check("ifid_instr_o", ifid_instr, e.ins);
            check("ifid_valid_o", {31'b0, ifid_valid}, {31'b0, e.v});
            check("misalign_o", {31'b0, misalign}, {31'b0, e.mis});
`ifdef FETCH_PERF_CNT_EN
            check("stall_cnt_o", stall_cnt, e.sc);
            check("flush_cnt_o", flush_cnt, e.fc);
            check("fetch_cnt_o", fetch_cnt, e.fe);
`endif
         end
      end
   end

   initial begin
      logic [31:0] t;
      m_pc = 0; m_ipc = 0; m_ins = c_NOP; m_v = 0; m_mis = 0;
      m_sc = 0; m_fc = 0; m_fe = 0;
      // Reset then idle
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0, 0, 0);
      // Straight-line fetch of pc 0 and 4
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      // Load-use stall with PC held, then resume
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      // Taken branch to 0x40, then fetch there
      step(0, 1, 1, 0, 1, 32'h40);
      step(0, 1, 1, 0, 0, 0);
      // Stall beats flush; then misaligned redirect
      step(0, 1, 0, 1, 1, 32'h80);
      step(0, 1, 1, 0, 1, 32'h82);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      // PC wrap
      step(0, 1, 1, 0, 1, 32'hFFFF_FFFC);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      // Reset during stall and during flush
      step(0, 1, 0, 1, 0, 0);
      step(1, 1, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 1, 32'h101);
      // Random traffic
      for (int i = 0; i < 600; i++) begin
         t = $urandom();
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 6) == 0), t);
      end
      @(posedge clk);
      #2;
      check("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
`default_nettype wire
